regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
- Parametrised general-purpose register file for core_lapido, successor to the fixed 16x32 bank.
- Configurable width and depth, two combinational read ports with write-through bypass, and one write port.
- Contents are cleared by a sequential one-entry-per-cycle sweep engine instead of a single-cycle clear, so the array maps to distributed RAM. The sweep runs after reset or on request.
- Sits in the decode stage: read ports feed operand muxes, write port is driven by writeback.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W (default 16 registers).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset.
- clr  input  1  request a full clear sweep (pulse, sampled at posedge).
- busy  output  1  high while the clear sweep is in progress.
- wr_drop  output  1  one-cycle pulse: a write was discarded because busy was high.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  DATA_W  read port A data.
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  DATA_W  read port B data.

Behaviour:
- Reset is synchronous, active-low; clk and rst are the only clock/reset, and no logic is asynchronous to clk.
- Reset (rst==0 at posedge):
  - clr_ptr<=0, busy<=1, wr_drop<=0.
  - Array is not cleared directly; the sweep clears it.
  - rdata_a/b read 0 while busy.
- States: IDLE (busy=0) and SWEEP (busy=1). Reset enters SWEEP.
- SWEEP:
  - Each posedge: mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
  - The cycle that writes entry DEPTH-1 sets busy<=0 and clr_ptr wraps to 0.
  - busy is therefore high for exactly DEPTH cycles after reset release (16 by default).
  - clr during SWEEP is ignored; the sweep is not restarted.
  - Reset during SWEEP restarts it at entry 0.
- IDLE + clr: busy<=1 at next posedge, then sweep as above.
- Write:
  - mem[waddr]<=wdata at posedge when we==1 and busy==0.
  - we==1 while busy==1: write discarded; wr_drop<=1 for exactly one cycle (registered). Otherwise wr_drop<=0.
  - we and clr in the same IDLE cycle: the write is performed, then cleared by the sweep; wr_drop stays 0.
- Read: combinational, zero latency.
  - busy==1: rdata=0.
  - Bypass: if we==1, busy==0 and waddr==raddr_x, then rdata_x=wdata (same-cycle write-through).
  - Otherwise rdata_x=mem[raddr_x].
  - Both ports may address the same entry simultaneously; both return identical data.
- All addresses are full-range (0..DEPTH-1), so no out-of-range case exists. clr_ptr is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Entry 0 is hardwired zero; writes to waddr==0 are silently ignored (no wr_drop).
  - Reads of address 0 always return 0, including through the bypass path.
- Not defined: entry 0 is an ordinary register.

Test Plan:
- Reset low 2 cycles then high -> busy==1 for exactly 16 cycles, then 0. rdata_a/b==0 throughout. wr_drop==0.
- Idle, write 0xDEADBEEF to reg 5, next cycle raddr_a=5 -> rdata_a==0xDEADBEEF. Set raddr_b=6 -> rdata_b==0.
- Same cycle we=1, waddr=3, wdata=0x12345678, raddr_a=3, raddr_b=3 -> both rdata==0x12345678 combinationally before the edge.
- Pulse clr, then we=1 on the next cycle (busy==1) -> wr_drop==1 for one cycle. Target register still 0 after the sweep ends (16 cycles).
- Fill regs 0..15 with 0xA0+i, pulse clr; assert rst low at sweep cycle 7 -> sweep restarts. busy stays high 16 cycles after rst release. All regs read 0 afterwards.
- With REGFILE_R0_ZERO_EN: write 0xFFFFFFFF to reg 0, read port A address 0 (including the same-cycle bypass) -> 0, wr_drop==0. Without the macro: reads 0xFFFFFFFF.

Source files
------------

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
// Parametrised register file for the decode stage: two combinational read
// ports with same-cycle write-through bypass and one write port. Contents are
// cleared by a sweep engine that zeroes one entry per cycle, so the array
// needs no multi-entry write path and stays a simple distributed RAM.
//
// Optional build macro: REGFILE_R0_ZERO_EN
//   defined     -> entry 0 reads as zero and writes to address 0 are ignored
//   not defined -> entry 0 is an ordinary register
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous active-low reset (starts a clear sweep)
//   clr      in   request a full clear sweep (ignored while busy)
//   busy     out  high while the clear sweep runs
//   wr_drop  out  one-cycle pulse: a write was discarded because busy was high
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data
//
// FSM states
//   state    | meaning
//   ST_IDLE  | array usable, reads/writes serviced
//   ST_SWEEP | clearing mem[clr_ptr] each cycle, reads return 0, writes dropped
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    output logic              wr_drop,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic [ADDR_W-1:0]   clr_ptr_d;
    logic                busy_q;
    logic                wr_drop_q;
    logic                wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                waddr_ok;
    logic                wr_en;
    logic                sweep_last;

    // Address 0 is not writable when entry 0 is hardwired to zero; such
    // writes vanish silently and never raise wr_drop.
`ifdef REGFILE_R0_ZERO_EN
    assign waddr_ok = (waddr != '0);
`else
    assign waddr_ok = 1'b1;
`endif

    assign wr_en      = we && !busy_q && waddr_ok;
    assign wr_drop_d  = we && busy_q && waddr_ok;
    assign sweep_last = &clr_ptr_q;
    assign clr_ptr_d  = clr_ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_SWEEP;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            wr_drop_q <= 1'b0;
        end else begin
            wr_drop_q <= wr_drop_d;
            case (state_q)
                ST_IDLE: begin
                    if (clr) begin
                        state_q   <= ST_SWEEP;
                        busy_q    <= 1'b1;
                        clr_ptr_q <= '0;
                    end
                end
                ST_SWEEP: begin
                    // Pointer wraps to 0 on the same edge that clears the
                    // last entry, so the next sweep starts from entry 0.
                    clr_ptr_q <= clr_ptr_d;
                    if (sweep_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_SWEEP;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // The reset edge itself does not touch the array; the sweep that
    // follows does the clearing, keeping a single write port on the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == ST_SWEEP) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_en) begin
                mem_q[waddr] <= wdata;
            end
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] val;
        if (busy_q) begin
            val = '0;
        end else if (wr_en && (waddr == raddr)) begin
            val = wdata;
        end else begin
            val = mem_q[raddr];
        end
`ifdef REGFILE_R0_ZERO_EN
        if (raddr == '0) begin
            val = '0;
        end
`endif
        return val;
    endfunction

    assign rdata_a = read_port(raddr_a);
    assign rdata_b = read_port(raddr_b);
    assign busy    = busy_q;
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
// Stimulus process drives one cycle at a time and pushes the expected
// outputs for that cycle into a queue; a monitor pops and compares on the
// falling edge. The reference model treats a clear as "all entries become
// zero, and the block is unavailable for DEPTH cycles", which is what the
// outside world observes.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          clr;
    logic          busy;
    logic          wr_drop;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] raddr_a;
    logic [DW-1:0] rdata_a;
    logic [AW-1:0] raddr_b;
    logic [DW-1:0] rdata_b;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .busy    (busy),
        .wr_drop (wr_drop),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .rdata_a (rdata_a),
        .raddr_b (raddr_b),
        .rdata_b (rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic          busy;
        logic          drop;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int unsigned cyc_no = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;     // cycles of unavailability remaining
    bit            m_drop;
    bit            m_valid;

    task automatic chk(input string name, input int unsigned c,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("busy",    e.cyc, {31'd0, busy},    {31'd0, e.busy});
            chk("wr_drop", e.cyc, {31'd0, wr_drop}, {31'd0, e.drop});
            chk("rdata_a", e.cyc, rdata_a, e.a);
            chk("rdata_b", e.cyc, rdata_b, e.b);
        end
    end

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra, input bit w,
                                             input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (m_left > 0) return '0;
        if (R0Z && ra == 0) return '0;
        if (w && wa == ra) return wd;
        return m_mem[ra];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_left = DEPTH;
    endtask

    task automatic cyc(input bit r, input bit c, input bit w,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
        exp_t e;
        bit   wr_ok;
        rst = r; clr = c; we = w; waddr = wa; wdata = wd; raddr_a = a; raddr_b = b;
        wr_ok = w && !(R0Z && wa == 0);
        if (m_valid) begin
            e.cyc  = cyc_no;
            e.busy = (m_left > 0);
            e.drop = m_drop;
            e.a    = exp_rd(a, wr_ok, wa, wd);
            e.b    = exp_rd(b, wr_ok, wa, wd);
            q.push_back(e);
        end
        @(posedge clk);
        cyc_no++;
        if (!r) begin
            model_clear();
            m_drop  = 1'b0;
            m_valid = 1'b1;
        end else if (m_left > 0) begin
            m_drop = wr_ok;
            m_left--;
        end else begin
            m_drop = 1'b0;
            if (wr_ok) m_mem[wa] = wd;
            if (c) model_clear();
        end
        #1;
    endtask

    task automatic idle(input int n, input logic [AW-1:0] a, input logic [AW-1:0] b);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, a, b);
    endtask

    initial begin
        m_valid = 1'b0;
        m_left  = 0;
        m_drop  = 1'b0;
        rst = 1'b0; clr = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0;
        @(posedge clk);
        #1;

        // Reset, then the post-reset sweep with reads returning 0
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) cyc(1, 0, 0, 0, 0, AW'(i), AW'(15 - i));

        // Plain write then read back, neighbour untouched
        cyc(1, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        cyc(1, 0, 0, 0, 0, 5, 6);

        // Same-cycle bypass on both ports
        cyc(1, 0, 1, 3, 32'h12345678, 3, 3);
        cyc(1, 0, 0, 0, 0, 3, 5);

        // Write during sweep is dropped and the target stays clear
        cyc(1, 1, 0, 0, 0, 5, 3);
        cyc(1, 0, 1, 9, 32'h55AA55AA, 9, 9);
        idle(DEPTH + 2, 9, 5);

        // Fill, clear, then reset in the middle of the sweep
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 1, AW'(i), 32'hA0 + i, AW'(i), 0);
        cyc(1, 1, 0, 0, 0, 4, 7);
        idle(7, 1, 2);
        cyc(0, 1, 0, 0, 0, 1, 2);
        idle(DEPTH + 1, 3, 4);
        for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, 0, 0, AW'(i), AW'(15 - i));

        // Entry 0 behaviour, including bypass
        cyc(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1);

        // Write and clear in the same idle cycle
        cyc(1, 0, 1, 7, 32'h0BADF00D, 7, 7);
        cyc(1, 1, 1, 7, 32'hCAFEF00D, 7, 0);
        idle(DEPTH + 1, 7, 0);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 79) != 0),
                ($urandom_range(0, 39) == 0),
                $urandom_range(0, 1),
                AW'($urandom_range(0, DEPTH - 1)),
                $urandom,
                AW'($urandom_range(0, DEPTH - 1)),
                AW'($urandom_range(0, DEPTH - 1)));
        end

        idle(2, 0, 0);
        repeat (2) @(negedge clk);
        tests_run++;
        if (q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
